// File: rtl/apb_lsu_master.sv
// RV32I load/store unit: one CPU request becomes one APB SETUP/ACCESS transfer,
// with byte-lane steering on stores and sign/zero extension on loads.
module apb_lsu_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wData,
    output logic [31:0] rData,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

    state_t        state_q;
    logic          we_q;
    logic [2:0]    func3_q;
    logic [1:0]    off_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q, paddr_q, pwdata_q;
    logic [3:0]    pstrb_q;
    logic          done_q, err_q, busy_q, psel_q, penable_q, pwrite_q;

    logic          legal_d, aligned_d;
    logic [31:0]   pwdata_d, ld_d;
    logic [3:0]    pstrb_d;
    logic [7:0]    byte_d;
    logic [15:0]   half_d;

    // Request decode on the live inputs; only consumed in IDLE.
    always_comb begin
        legal_d = 1'b0;
        case (func3)
            3'b000, 3'b001, 3'b010: legal_d = 1'b1;
            3'b100, 3'b101:         legal_d = !we;
            default:                legal_d = 1'b0;
        endcase
        case (func3[1:0])
            2'b01:   aligned_d = !addr[0];
            2'b10:   aligned_d = (addr[1:0] == 2'b00);
            default: aligned_d = 1'b1;
        endcase
        pwdata_d = 32'h0;
        pstrb_d  = 4'b0000;
        if (we) begin
            case (func3[1:0])
                2'b00: begin
                    pwdata_d = {4{wData[7:0]}};
                    pstrb_d  = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    pwdata_d = {2{wData[15:0]}};
                    pstrb_d  = addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    pwdata_d = wData;
                    pstrb_d  = 4'b1111;
                end
            endcase
        end
    end

    // Load lane select and extension from the latched request.
    always_comb begin
        case (off_q)
            2'd0:    byte_d = PRDATA[7:0];
            2'd1:    byte_d = PRDATA[15:8];
            2'd2:    byte_d = PRDATA[23:16];
            default: byte_d = PRDATA[31:24];
        endcase
        half_d = off_q[1] ? PRDATA[31:16] : PRDATA[15:0];
        case (func3_q)
            3'b000:  ld_d = {{24{byte_d[7]}}, byte_d};
            3'b001:  ld_d = {{16{half_d[15]}}, half_d};
            3'b100:  ld_d = {24'h0, byte_d};
            3'b101:  ld_d = {16'h0, half_d};
            default: ld_d = PRDATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            func3_q   <= 3'b0;
            off_q     <= 2'b0;
            cnt_q     <= '0;
            rdata_q   <= 32'h0;
            paddr_q   <= 32'h0;
            pwdata_q  <= 32'h0;
            pstrb_q   <= 4'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (req) begin
                    we_q    <= we;
                    func3_q <= func3;
                    off_q   <= addr[1:0];
                    busy_q  <= 1'b1;
                    if (legal_d && aligned_d) begin
                        state_q  <= S_SETUP;
                        psel_q   <= 1'b1;
                        paddr_q  <= {addr[31:2], 2'b00};
                        pwrite_q <= we;
                        pwdata_q <= pwdata_d;
                        pstrb_q  <= pstrb_d;
                    end else begin
                        // Rejected requests never touch the bus.
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end
                end
                S_SETUP: begin
                    state_q   <= S_ACCESS;
                    penable_q <= 1'b1;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        state_q   <= S_DONE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= PSLVERR;
                        cnt_q     <= '0;
                        if (!we_q)
                            rdata_q <= PSLVERR ? 32'h0 : ld_d;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (cnt_q + CW'(1) == TO_LIM) begin
                            state_q   <= S_DONE;
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                            done_q    <= 1'b1;
                            err_q     <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rData   = rdata_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign PADDR   = paddr_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;
    assign PSTRB   = pstrb_q;
endmodule

// File: tb/tb_apb_lsu_master.sv
// Directed bench for apb_lsu_master: stimulus pushes expected completions into a
// queue, a negedge monitor pops and compares each done pulse.
module tb_apb_lsu_master;
    logic        clk = 1'b0;
    logic        reset, req, we;
    logic [2:0]  func3;
    logic [31:0] addr, wData, rData, PADDR, PWDATA, PRDATA;
    logic        done, err, busy, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [3:0]  PSTRB;

    apb_lsu_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .func3(func3), .addr(addr),
        .wData(wData), .rData(rData), .done(done), .err(err), .busy(busy),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0, bad = 0;
    int          cyc = 0, req_cyc = 0;
    int          wait_n = 0, acc_cnt = 0, acc_seen = 0;
    logic        slv_err = 1'b0, psel_seen = 1'b0;
    logic [31:0] prdata_v = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: ready after wait_n ACCESS cycles, driven away from the edge.
    always @(negedge clk) begin
        if (PSEL) psel_seen = 1'b1;
        if (PSEL && PENABLE) begin
            PREADY  = (acc_cnt >= wait_n);
            PSLVERR = slv_err && PREADY;
            PRDATA  = prdata_v;
            acc_cnt++;
            acc_seen++;
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            acc_cnt = 0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("err", 32'(err), 32'(e.err));
                    chk("rData", rData, e.rd);
                    chk("latency", 32'(cyc - req_cyc), 32'(e.lat));
                    chk("psel_at_done", 32'(PSEL), 32'h0);
                end
            end else begin
                chk("err_without_done", 32'(err), 32'h0);
            end
        end
    end

    task automatic start(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input int wn, input logic se,
                         input logic [31:0] pd, input logic ee, input logic [31:0] er,
                         input int lat);
        exp_t e;
        @(negedge clk);
        wait_n = wn; slv_err = se; prdata_v = pd;
        psel_seen = 1'b0; acc_seen = 0;
        req = 1'b1; we = w; func3 = f; addr = a; wData = wd;
        e.err = ee; e.rd = er; e.lat = lat;
        exp_q.push_back(e);
        req_cyc = cyc;
        @(posedge clk); #1;
        // Scramble inputs: the DUT must work from its latched copy.
        req = 1'b0; addr = ~a; wData = ~wd; func3 = ~f; we = ~w;
    endtask

    task automatic finish();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; func3 = 3'b0; addr = 32'h0; wData = 32'h0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_psel", 32'(PSEL), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rData", rData, 32'h0);
        chk("rst_paddr", PADDR, 32'h0);
        reset = 1'b0;

        // SB with lane replication
        start(1, 3'b000, 32'h5, 32'h1234_56AB, 0, 0, 32'h0, 0, 32'h0, 3);
        chk("sb_psel", 32'(PSEL), 32'h1);
        chk("sb_penable", 32'(PENABLE), 32'h0);
        chk("sb_paddr", PADDR, 32'h4);
        chk("sb_pwdata", PWDATA, 32'hABAB_ABAB);
        chk("sb_pstrb", 32'(PSTRB), 32'h2);
        chk("sb_pwrite", 32'(PWRITE), 32'h1);
        chk("sb_busy", 32'(busy), 32'h1);
        @(posedge clk); #1;
        chk("sb_access_penable", 32'(PENABLE), 32'h1);
        chk("sb_access_pwdata", PWDATA, 32'hABAB_ABAB);
        finish();

        // Loads and extension
        start(0, 3'b000, 32'h7, 32'h0, 0, 0, 32'h80AA_5511, 0, 32'hFFFF_FF80, 3);
        chk("lb_pstrb", 32'(PSTRB), 32'h0);
        chk("lb_pwrite", 32'(PWRITE), 32'h0);
        chk("lb_paddr", PADDR, 32'h4);
        finish();
        start(0, 3'b100, 32'h7, 32'h0, 0, 0, 32'h80AA_5511, 0, 32'h0000_0080, 3); finish();
        start(0, 3'b101, 32'h2, 32'h0, 0, 0, 32'h80AA_5511, 0, 32'h0000_80AA, 3); finish();
        start(0, 3'b001, 32'h0, 32'h0, 0, 0, 32'h80AA_5511, 0, 32'h0000_5511, 3); finish();
        start(0, 3'b001, 32'h2, 32'h0, 0, 0, 32'h80AA_5511, 0, 32'hFFFF_80AA, 3); finish();
        start(0, 3'b010, 32'h4, 32'h0, 2, 0, 32'h80AA_5511, 0, 32'h80AA_5511, 5); finish();

        // Misaligned / illegal: no bus activity, rData held
        start(0, 3'b010, 32'h6, 32'h0, 0, 0, 32'h0, 1, 32'h80AA_5511, 1); finish();
        chk("misal_lw_psel", 32'(psel_seen), 32'h0);
        start(0, 3'b011, 32'h8, 32'h0, 0, 0, 32'h0, 1, 32'h80AA_5511, 1); finish();
        chk("illegal_ld_psel", 32'(psel_seen), 32'h0);
        start(1, 3'b100, 32'h8, 32'h0, 0, 0, 32'h0, 1, 32'h80AA_5511, 1); finish();
        chk("illegal_st_psel", 32'(psel_seen), 32'h0);
        start(0, 3'b001, 32'h1, 32'h0, 0, 0, 32'h0, 1, 32'h80AA_5511, 1); finish();
        chk("misal_lh_psel", 32'(psel_seen), 32'h0);

        // SW with wait states and slave error
        start(1, 3'b010, 32'h10, 32'hDEAD_BEEF, 3, 1, 32'h0, 1, 32'h80AA_5511, 6);
        chk("sw_pstrb", 32'(PSTRB), 32'hF);
        chk("sw_pwdata", PWDATA, 32'hDEAD_BEEF);
        chk("sw_paddr", PADDR, 32'h10);
        finish();
        chk("sw_access_cycles", 32'(acc_seen), 32'd4);

        // SH upper half
        start(1, 3'b001, 32'h6, 32'h0000_CAFE, 0, 0, 32'h0, 0, 32'h80AA_5511, 3);
        chk("sh_pwdata", PWDATA, 32'hCAFE_CAFE);
        chk("sh_pstrb", 32'(PSTRB), 32'hC);
        chk("sh_paddr", PADDR, 32'h4);
        finish();

        // Load with slave error clears rData
        start(0, 3'b010, 32'h8, 32'h0, 0, 1, 32'h1111_2222, 1, 32'h0, 3); finish();

        // Timeout: 16 ACCESS cycles, rData held
        start(0, 3'b010, 32'hC, 32'h0, 100, 0, 32'h3333_4444, 1, 32'h0, 18); finish();
        chk("timeout_access_cycles", 32'(acc_seen), 32'd16);
        @(negedge clk);
        chk("timeout_psel_after", 32'(PSEL), 32'h0);
        chk("timeout_busy_after", 32'(busy), 32'h0);

        // Reset in ACCESS aborts without a done pulse
        start(1, 3'b010, 32'h20, 32'h5555_AAAA, 100, 0, 32'h0, 0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_penable", 32'(PENABLE), 32'h1);
        reset = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        chk("abort_psel", 32'(PSEL), 32'h0);
        chk("abort_penable", 32'(PENABLE), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // New request after reset
        start(0, 3'b100, 32'h1, 32'h0, 0, 0, 32'h80AA_5511, 0, 32'h0000_0055, 3); finish();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule
